// File: rtl/seg_pkg.sv
// Shared constants for the six-digit seven-segment display driver:
// segment codes, converter state encoding and the nibble decoder.
package seg_pkg;

    localparam int DIGITS = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_display_driver_bin2bcd.sv
// Sequential double-dabble: 20-bit binary to 24-bit BCD in 20 shift cycles,
// followed by one commit cycle where done is high.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] bin,
    output logic        busy,
    output logic        done,
    output logic [23:0] bcd
);

    logic [1:0]  state;
    logic [19:0] sh;
    logic [4:0]  cnt;
    logic [23:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            sh    <= '0;
            bcd   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sh    <= bin;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd, sh} <= {adj[22:0], sh, 1'b0};
                    cnt       <= cnt + 5'd1;
                    if (cnt == 5'd19)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done = (state == ST_COMMIT);

endmodule

// File: rtl/seg_display_driver.sv
// Converts a 20-bit value to BCD and scans it onto a 6-digit common-anode
// display with leading-zero blanking and dash-style overflow.
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int MAX_DISP = 999999
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] value,
    output logic [7:0]  seg,
    output logic [5:0]  sel,
    output logic        busy
);

    localparam int          CW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [19:0] MAX_V = 20'(MAX_DISP);

    logic [19:0]   latched;
    logic          restart;
    logic          start;
    logic          done;
    logic [23:0]   bcd_work;
    logic [23:0]   disp_bcd;
    logic          ovf;
    logic [CW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [7:0]    digit_seg [DIGITS];

    assign start = (value != latched) || restart;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (value),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd_work)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            latched  <= '0;
            restart  <= 1'b1;
            disp_bcd <= '0;
            ovf      <= 1'b0;
        end else begin
            if (start && !busy) begin
                latched <= value;
                restart <= 1'b0;
            end
            if (done) begin
                disp_bcd <= bcd_work;
                ovf      <= (latched > MAX_V);
            end
        end
    end

    // Blank a digit while it and everything above it are still zero
    always_comb begin
        logic       lead;
        logic [3:0] nib;
        lead = 1'b1;
        nib  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib  = disp_bcd[4*i +: 4];
            lead = lead && (nib == 4'd0);
            if (ovf)
                digit_seg[i] = SEG_DASH;
            else if (lead && i != 0)
                digit_seg[i] = SEG_BLANK;
            else
                digit_seg[i] = seg_code(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            sel      <= 6'h3F;
            seg      <= SEG_BLANK;
        end else begin
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            sel <= ~(6'd1 << idx);
            seg <= digit_seg[idx];
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a short scan period.
// Digits are gathered over a full scan and compared to hand-made codes.
module tb_seg_display_driver;

    logic        clk;
    logic        rst;
    logic [19:0] value;
    logic [7:0]  seg;
    logic [5:0]  sel;
    logic        busy;

    int tests;
    int fails;

    logic [7:0] got [6];
    int         bad;

    seg_display_driver #(.SCAN_DIV(4), .MAX_DISP(999999)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .seg   (seg),
        .sel   (sel),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
    endtask

    task automatic convert(input string tag, input logic [19:0] v);
        int n;
        value = v;
        wait_fall(n);
        chk(tag, n, 22);
    endtask

    task automatic capture();
        logic [5:0] prev;
        prev = 6'h3F;
        bad  = 0;
        for (int k = 0; k < 6; k++) got[k] = 8'h00;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if ($countones(~sel) != 1) begin
                bad++;
            end else begin
                for (int k = 0; k < 6; k++)
                    if (sel == ~(6'd1 << k)) got[k] = seg;
                if (prev != 6'h3F && sel != prev &&
                    sel != {prev[4:0], prev[5]})
                    bad++;
            end
            prev = sel;
        end
    endtask

    task automatic check_digits(input string tag, input logic [47:0] e);
        capture();
        chk({tag, "_scan"}, bad, 0);
        for (int k = 0; k < 6; k++)
            chk($sformatf("%s_d%0d", tag, k), got[k], e[8*k +: 8]);
    endtask

    initial begin
        int n;
        int m;
        int wbad;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        value = 20'd0;

        @(negedge clk);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_sel", sel, 6'h3F);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_sel2", sel, 6'h3F);
        rst = 1'b0;
        wait_fall(n);
        chk("lat_after_rst", n, 22);
        check_digits("zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

        convert("lat_1024", 20'd1024);
        check_digits("v1024", {8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hA4, 8'h99});

        convert("lat_999999", 20'd999999);
        check_digits("v999999", {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});

        convert("lat_1000000", 20'd1000000);
        check_digits("ovf1", {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF});

        convert("lat_fffff", 20'hFFFFF);
        check_digits("ovf2", {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF});

        convert("lat_507", 20'd507);
        check_digits("v507", {8'hFF, 8'hFF, 8'hFF, 8'h92, 8'hC0, 8'hF8});

        value = 20'd2;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n++;
        end
        value = 20'd3;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("lat_2_first", n, 22);
        @(negedge clk);
        chk("busy_gap", busy, 1);
        m    = 1;
        wbad = 0;
        while (busy && m < 60) begin
            if (sel == 6'h3E) begin
                if (seg !== 8'hA4) wbad++;
            end else if (seg !== 8'hFF) begin
                wbad++;
            end
            @(negedge clk);
            m++;
        end
        chk("first_commit_2", wbad, 0);
        chk("lat_3_second", m, 22);
        check_digits("v3", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB0});

        value = 20'd4;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_seg", seg, 8'hFF);
        chk("mid_rst_sel", sel, 6'h3F);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        wait_fall(n);
        chk("lat_after_mid_rst", n, 22);
        check_digits("v4", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
Consumes the 20-bit binary display value produced by the key-handling logic and drives a 6-digit multiplexed common-anode seven-segment display. A sequential double-dabble converter turns the binary value into BCD. A scan timer then time-multiplexes the six digits. Leading-zero blanking and overflow indication are included. The block sits between the key/value logic and the board's seg/sel pins.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is lit (1 ms at 50 MHz); sim uses 4
MAX_DISP, 999999, largest value shown numerically

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
value  input  20  unsigned binary value to display
seg  output  8  segment drive, active-low, bit7=dp (always 1), bit6..0 = g..a
sel  output  6  digit select, active-low one-hot, sel[0] = rightmost digit
busy  output  1  high while a BCD conversion is in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: seg=8'hFF, sel=6'h3F, busy=0, latched value=0, displayed BCD=0, digit index=0, scan count=0, FSM=IDLE, restart flag=1. A conversion is therefore forced right after reset.
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: if value != latched, or restart flag=1, go to SHIFT. Latch value, clear the shift/BCD work registers, clear restart, set busy=1.
  - SHIFT: exactly 20 cycles. Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd, bin} left by 1. After the 20th shift, go to COMMIT.
  - COMMIT: one cycle. Copy the working BCD into the display register, go to IDLE, set busy=0.
- Latency: 22 clk from the first cycle value differs (IDLE sample) to the display register update. Displayed digits change only at COMMIT; partial results never appear on seg.
- value changing during SHIFT/COMMIT is ignored. On return to IDLE the new value differs from latched and a new conversion starts immediately. The final stable value is always displayed.
- Overflow: if latched value > MAX_DISP, COMMIT stores an overflow flag instead of BCD. All six digits then show dash (8'hBF).
- Scan:
  - The scan count runs 0..SCAN_DIV-1. On wrap, the digit index increments 0..5 and wraps 5->0.
  - sel and seg are registered and update one clk after the index changes. sel = ~(1<<index).
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF, dash=BF.
- Leading-zero blanking: digit i (i>=1) is blank when digit i and every digit above it are 0. Digit 0 always shows. Value 0 therefore shows a single "0" at the rightmost position.
- Reset mid-conversion: conversion is abandoned and everything returns to reset values. The next cycles start a fresh conversion of the current value.

Decomposition:
- Package seg_pkg holds:
  - DIGITS=6
  - the 8-bit segment constants (SEG_0..SEG_9, SEG_BLANK, SEG_DASH)
  - the FSM state encoding
  - a function mapping a nibble to its segment code
- One sub-module, bin2bcd_seq: the 20-bit to 24-bit sequential double-dabble converter (start/busy/done handshake).
- Scan and blanking logic stays in the top module.

Test Plan:
1. Assert rst 2 cycles, value=0, SCAN_DIV=4 -> seg=FF/sel=3F during reset. After 22 clk busy falls. While sel=3E, seg=C0; all other digits seg=FF.
2. value=1024 -> busy high for 22 clk. Digits 3..0 show F9, C0, A4, 99; digits 5,4 blank. The full 6-digit cycle is 24 clk.
3. value=999999 -> all six digits show 90. value=1000000 or 20'hFFFFF -> all six digits show BF.
4. value 2->3 on the 5th SHIFT cycle -> first COMMIT shows 2. A second conversion starts the cycle after, and 3 appears 22 clk later. busy stays low for exactly 1 cycle between conversions.
5. rst asserted during SHIFT with value=4 -> outputs are at reset values on the next edge. After release, 4 is displayed 22 clk later.
6. Scan wrap -> after index 5, the next update has sel=3E. No cycle ever has more than one sel bit low.
